// File: rtl/mem_sp_sram_ctrl.sv
// Single-port SRAM controller with write/read arbitration and registered SRAM command.
// Optional macro MEM_SP_SRAM_CTRL_RDATA_REG_EN registers mem_rdata (read latency +1).
module mem_sp_sram_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int SRAM_RD_LAT = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  mem_wr_en,
  input  logic [STRB_WIDTH-1:0] mem_wstrb,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rd_en,
  input  logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [STRB_WIDTH-1:0] sram_be,
  output logic [ADDR_WIDTH-$clog2(STRB_WIDTH)-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int BW = $clog2(STRB_WIDTH);
  localparam logic [1:0] LAT_M1 = 2'(SRAM_RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_WAIT,
    RD_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       last_rd_q, last_rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ready_d;
  logic       grant_wr, grant_rd;

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state_q)
      IDLE: begin
        // a registered read completion is still on the bus here
        if (!mem_ready) begin
          if (mem_wr_en && mem_rd_en) begin
            grant_wr = last_rd_q;
            grant_rd = !last_rd_q;
          end else begin
            grant_wr = mem_wr_en;
            grant_rd = mem_rd_en;
          end
        end
        if (grant_wr) begin
          state_d   = WR;
          last_rd_d = 1'b0;
          ready_d   = 1'b1;
        end
        if (grant_rd) begin
          state_d   = RD_WAIT;
          last_rd_d = 1'b1;
          cnt_d     = 2'd0;
        end
      end
      WR: state_d = IDLE;
      RD_WAIT: begin
        if (cnt_q == LAT_M1) begin
          state_d = RD_DONE;
          cnt_d   = 2'd0;
`ifndef MEM_SP_SRAM_CTRL_RDATA_REG_EN
          ready_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
`ifdef MEM_SP_SRAM_CTRL_RDATA_REG_EN
        ready_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
      cnt_q     <= 2'd0;
      mem_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      cnt_q     <= cnt_d;
      mem_ready <= ready_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_be    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_ce    <= grant_wr | grant_rd;
      sram_we    <= grant_wr;
      sram_be    <= grant_wr ? mem_wstrb : '0;
      sram_wdata <= grant_wr ? mem_wdata : '0;
      if (grant_wr)
        sram_addr <= mem_waddr[ADDR_WIDTH-1:BW];
      else if (grant_rd)
        sram_addr <= mem_raddr[ADDR_WIDTH-1:BW];
      else
        sram_addr <= '0;
    end
  end

`ifdef MEM_SP_SRAM_CTRL_RDATA_REG_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      mem_rdata <= '0;
    else if (state_q == RD_DONE)
      mem_rdata <= sram_rdata;
  end
`else
  assign mem_rdata = (state_q == RD_DONE) ? sram_rdata : '0;
`endif

  generate
    if (BW > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^{mem_waddr[BW-1:0], mem_raddr[BW-1:0]};
    end
  endgenerate

endmodule

// File: tb/tb_mem_sp_sram_ctrl.sv
// Directed bench for mem_sp_sram_ctrl: vector table plus
// tie, back-to-back and mid-read reset sequences.
module tb_mem_sp_sram_ctrl;

`ifdef MEM_SP_SRAM_CTRL_RDATA_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int RLAT = LAT + 1 + EXTRA;
  localparam int PER  = LAT + 2 + EXTRA;

  logic        clk;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [3:0]  wstrb;
  logic [15:0] waddr, raddr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        sram_ce, sram_we;
  logic [3:0]  sram_be;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  logic        rst3_n, rd3;
  logic [31:0] rdata3;
  logic        ready3, ce3, we3;
  logic [3:0]  be3;
  logic [13:0] addr3;
  logic [31:0] wdata3;
  logic [31:0] sram_rdata3;

  int checks = 0;
  int errors = 0;

  mem_sp_sram_ctrl #(.SRAM_RD_LAT(LAT)) u_dut (
    .aclk(clk), .aresetn(rst_n),
    .mem_wr_en(wr_en), .mem_wstrb(wstrb),
    .mem_waddr(waddr), .mem_wdata(wdata),
    .mem_rd_en(rd_en), .mem_raddr(raddr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_be(sram_be), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  mem_sp_sram_ctrl #(.SRAM_RD_LAT(LAT3)) u_lat3 (
    .aclk(clk), .aresetn(rst3_n),
    .mem_wr_en(1'b0), .mem_wstrb(4'h0),
    .mem_waddr(16'h0000), .mem_wdata(32'h0),
    .mem_rd_en(rd3), .mem_raddr(16'h0024),
    .mem_rdata(rdata3), .mem_ready(ready3),
    .sram_ce(ce3), .sram_we(we3),
    .sram_be(be3), .sram_addr(addr3),
    .sram_wdata(wdata3), .sram_rdata(sram_rdata3)
  );

  assign sram_rdata3 = 32'h3C3C_0009;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural SRAM with LAT-cycle read pipe
  logic [31:0] mem [0:63];
  logic [31:0] pipe [0:LAT-1];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {4{8'(i)}};
  end

  always @(posedge clk) begin
    if (sram_ce && sram_we)
      for (int b = 0; b < 4; b++)
        if (sram_be[b]) mem[sram_addr[5:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    pipe[0] <= (sram_ce && !sram_we) ? mem[sram_addr[5:0]] : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sram_rdata = pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [8];

  task automatic run_vec(input vec_t v);
    int n;
    bit seen;
    seen = 0;
    @(negedge clk);
    wr_en = v.w;
    rd_en = !v.w;
    waddr = v.a;
    raddr = v.a;
    wstrb = v.s;
    wdata = v.d;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("ce", 32'(sram_ce), 32'd1);
        chk("we", 32'(sram_we), 32'(v.w));
        chk("addr", 32'(sram_addr), 32'(v.a[15:2]));
        chk("be", 32'(sram_be), v.w ? 32'(v.s) : 32'd0);
        chk("wdata", sram_wdata, v.w ? v.d : 32'd0);
      end
      if (mem_ready) begin
        seen = 1;
        break;
      end
    end
    wr_en = 0;
    rd_en = 0;
    if (!seen) chk("ready_timeout", 32'd0, 32'd1);
    else begin
      chk("latency", 32'(n), v.w ? 32'd1 : 32'(RLAT));
      if (!v.w) chk("rdata", mem_rdata, v.exp);
    end
    @(negedge clk);
    chk("ready_pulse", 32'(mem_ready), 32'd0);
  endtask

  initial begin
    int nce, nrdy, last, cyc;
    bit consec, prev;
    logic seq [4];
    int rdy_at [4];

    tv[0] = '{1'b1, 16'h0010, 4'hF, 32'hA5A5_5A5A, 32'h0};
    tv[1] = '{1'b0, 16'h0010, 4'h0, 32'h0,         32'hA5A5_5A5A};
    tv[2] = '{1'b1, 16'h0013, 4'h2, 32'h1122_3344, 32'h0};
    tv[3] = '{1'b0, 16'h0012, 4'h0, 32'h0,         32'hA5A5_335A};
    tv[4] = '{1'b1, 16'h0020, 4'h0, 32'hFFFF_FFFF, 32'h0};
    tv[5] = '{1'b0, 16'h0020, 4'h0, 32'h0,         32'h0808_0808};
    tv[6] = '{1'b1, 16'h00FC, 4'hC, 32'h1234_5678, 32'h0};
    tv[7] = '{1'b0, 16'h00FC, 4'h0, 32'h0,         32'h1234_3F3F};

    rst_n = 0; rst3_n = 0; rd3 = 0;
    wr_en = 0; rd_en = 0; wstrb = 0;
    waddr = 0; raddr = 0; wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_ce", 32'(sram_ce), 32'd0);
    chk("rst_we", 32'(sram_we), 32'd0);
    chk("rst_be", 32'(sram_be), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_wdata", sram_wdata, 32'd0);
    rst_n = 1; rst3_n = 1;

    // tie right after reset: W,R,W,R
    wr_en = 1; rd_en = 1;
    waddr = 16'h0040; raddr = 16'h0040;
    wstrb = 4'hF; wdata = 32'hCAFE_0001;
    nce = 0; nrdy = 0; consec = 0; prev = 0;
    for (int c = 0; c < 40 && nrdy < 4; c++) begin
      @(negedge clk);
      if (sram_ce && nce < 4) begin
        seq[nce] = sram_we;
        nce++;
      end
      if (mem_ready && prev) consec = 1;
      if (mem_ready) nrdy++;
      prev = mem_ready;
    end
    wr_en = 0; rd_en = 0;
    chk("tie_grants", 32'(nce), 32'd4);
    chk("tie_readies", 32'(nrdy), 32'd4);
    chk("tie_consec", 32'(consec), 32'd0);
    chk("tie_g0", 32'(seq[0]), 32'd1);
    chk("tie_g1", 32'(seq[1]), 32'd0);
    chk("tie_g2", 32'(seq[2]), 32'd1);
    chk("tie_g3", 32'(seq[3]), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tv[i]);

    // back-to-back reads, request held
    @(negedge clk);
    rd_en = 1; raddr = 16'h0010;
    nrdy = 0; consec = 0; prev = 0; cyc = 0;
    while (nrdy < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mem_ready && prev) consec = 1;
      if (mem_ready) begin
        rdy_at[nrdy] = cyc;
        chk("b2b_rdata", mem_rdata, 32'hA5A5_335A);
        nrdy++;
      end
      prev = mem_ready;
    end
    rd_en = 0;
    chk("b2b_count", 32'(nrdy), 32'd4);
    chk("b2b_consec", 32'(consec), 32'd0);
    for (int i = 1; i < 4; i++)
      if (i < nrdy) chk("b2b_period", 32'(rdy_at[i] - rdy_at[i-1]), 32'(PER));
    @(negedge clk);

    // reset in RD_WAIT with SRAM_RD_LAT=3
    rd3 = 1;
    @(negedge clk);
    chk("l3_strobe", 32'(ce3), 32'd1);
    rd3 = 0;
    @(negedge clk);
    #2 rst3_n = 0;
    #1;
    chk("l3_rst_ready", 32'(ready3), 32'd0);
    chk("l3_rst_rdata", rdata3, 32'd0);
    chk("l3_rst_cmd", {we3, ce3, be3, wdata3[25:0]}, 32'd0);
    chk("l3_rst_addr", 32'(addr3), 32'd0);
    consec = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready3 || ce3) consec = 1;
    end
    chk("l3_dropped", 32'(consec), 32'd0);
    rd3 = 1;
    rst3_n = 1;
    @(negedge clk);
    chk("l3_first_grant", 32'(ce3), 32'd1);
    last = 0;
    for (int n = 2; n <= 12; n++) begin
      @(negedge clk);
      if (ready3) begin
        last = n;
        break;
      end
    end
    rd3 = 0;
    chk("l3_latency", 32'(last), 32'(LAT3 + 1 + EXTRA));
    chk("l3_rdata", rdata3, 32'h3C3C_0009);
    @(negedge clk);
    chk("l3_pulse", 32'(ready3), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_sp_sram_ctrl.md
MEM_SP_SRAM_CTRL -- requirements
Module: mem_sp_sram_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, memory data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, byte address width.
REQ-003 The block SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-004 The block SHALL have parameter SRAM_RD_LAT, default 1, legal 1..4, cycles from SRAM read strobe to sram_rdata valid.
REQ-005 The block SHALL have the port aclk, input, 1, the single clock; all flops rise on aclk.
REQ-006 The block SHALL have the port aresetn, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have the ports mem_wr_en / mem_wstrb / mem_waddr / mem_wdata, inputs, 1 / STRB_WIDTH / ADDR_WIDTH / DATA_WIDTH, the write request, held until mem_ready.
REQ-008 The block SHALL have the ports mem_rd_en / mem_raddr, inputs, 1 / ADDR_WIDTH, the read request, held until mem_ready.
REQ-009 The block SHALL have the ports mem_rdata / mem_ready, outputs, DATA_WIDTH / 1, read data and the completion pulse.
REQ-010 The block SHALL have the ports sram_ce / sram_we / sram_be / sram_addr / sram_wdata, outputs, 1 / 1 / STRB_WIDTH / ADDR_WIDTH-log2(STRB_WIDTH) / DATA_WIDTH, single-port SRAM command.
REQ-011 The block SHALL have the port sram_rdata, input, DATA_WIDTH, SRAM read data.

Function
REQ-012 The FSM SHALL have the states IDLE, WR, RD_WAIT and RD_DONE, and SHALL leave reset in IDLE.
REQ-013 In IDLE with exactly one request asserted, the FSM SHALL latch that request and move to WR (write) or RD_WAIT (read) on the next edge.
REQ-014 In IDLE with both requests asserted, the FSM SHALL grant the type not granted last, SHALL update the last_grant flop on every grant, and SHALL hold last_grant=read after reset so that write wins the first tie.
REQ-015 The sram_* outputs SHALL be registered and SHALL equal zero except during the single access cycle.
REQ-016 sram_addr SHALL be the latched address bits [ADDR_WIDTH-1:log2(STRB_WIDTH)], and the low address bits SHALL be ignored.
REQ-017 In WR, the block SHALL drive sram_ce=1, sram_we=1, sram_be=wstrb and sram_wdata=wdata for one cycle, SHALL assert mem_ready in the same cycle, and SHALL return to IDLE.
REQ-018 Write latency SHALL be 1 cycle (request sampled in cycle t, mem_ready in t+1).
REQ-019 On RD_WAIT entry, the block SHALL drive sram_ce=1 and sram_we=0 for one cycle, and a counter SHALL count SRAM_RD_LAT cycles before the FSM moves to RD_DONE.
REQ-020 In RD_DONE, sram_rdata SHALL be valid, mem_ready SHALL pulse for one cycle (subject to REQ-028/029), and the FSM SHALL return to IDLE.
REQ-021 mem_ready SHALL never be high for two consecutive cycles.
REQ-022 In the cycle after mem_ready, the FSM SHALL be in IDLE and SHALL sample the requests anew.
REQ-023 Request inputs SHALL be ignored outside IDLE, and changes to a request after acceptance SHALL not affect the access in flight.
REQ-024 An all-zero wstrb SHALL still perform the WR cycle (sram_be=0) and SHALL return mem_ready.

Reset
REQ-025 On aresetn low, the block SHALL asynchronously force state=IDLE, last_grant=read, counter=0, mem_ready=0, mem_rdata=0, and all sram_* outputs to 0.
REQ-026 If reset is asserted mid-access, the in-flight access SHALL be dropped with no mem_ready.
REQ-027 After reset release, the first possible grant SHALL occur on the first rising edge with aresetn high.

Configuration
REQ-028 Macro MEM_SP_SRAM_CTRL_RDATA_REG_EN defined: mem_rdata SHALL be a register loaded from sram_rdata in RD_DONE, mem_ready for reads SHALL be delayed one cycle, read latency SHALL be SRAM_RD_LAT+2, and mem_rdata SHALL hold its value until the next read.
REQ-029 Macro undefined: mem_rdata SHALL equal sram_rdata combinationally, SHALL be valid only while mem_ready is high, and read latency SHALL be SRAM_RD_LAT+1.

Verification
REQ-030 Single write: wr_en=1, waddr=0x0010, wstrb=0xF, wdata=0xA5A5_5A5A -> next cycle sram_ce=sram_we=1, sram_addr=0x004, mem_ready=1.
REQ-031 Single read, SRAM_RD_LAT=1, macro off: rd_en=1, raddr=0x0010, SRAM returns 0xA5A5_5A5A -> mem_ready and mem_rdata=0xA5A5_5A5A two cycles after the request; with the macro on, three cycles after.
REQ-032 Tie: wr_en and rd_en held together for four grants right after reset -> grant order W,R,W,R, with exactly one mem_ready per access.
REQ-033 Reset mid-read: aresetn low in RD_WAIT with SRAM_RD_LAT=3 -> all outputs 0 immediately, no mem_ready, and the FSM in IDLE after release.
REQ-034 Back-to-back reads with requests held continuously -> no consecutive-cycle mem_ready, and one read completes every SRAM_RD_LAT+2 cycles (macro off).
REQ-035 Partial write wstrb=0x2 -> sram_be=0x2, and a read-back shows only byte 1 changed.
